// File: rtl/irq_req_latch.sv
// Interrupt request front end: synchronises external request lines, latches
// rising edges as pending bits until acknowledged, and masks them toward the core.
module irq_req_latch #(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter bit               EDGE_MODE   = 1'b1,
  parameter logic [WIDTH-1:0] MASK_RESET  = 8'hFF
) (
  input  logic             ph1,
  input  logic             reset,
  input  logic [WIDTH-1:0] irq_in,
  input  logic             ack_valid,
  input  logic [2:0]       ack_idx,
  input  logic             mask_we,
  input  logic [WIDTH-1:0] mask_wdata,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] interrupts,
  output logic [WIDTH-1:0] pending,
  output logic             irq_any,
  output logic [2:0]       irq_idx,
  output logic [WIDTH-1:0] overflow,
  output logic [WIDTH-1:0] mask
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] hist_q;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] ovf_q, ovf_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] ack_hit;
  logic [WIDTH-1:0] ovf_set;

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign rise   = sync_s & ~hist_q;

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  always_comb begin
    ack_hit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ack_hit[i] = ack_valid && (int'(ack_idx) == i);
    end
  end

  // A new rising edge always wins over an ack of the same line.
  always_comb begin
    ovf_set = '0;
    if (EDGE_MODE) begin
      ovf_set = rise & pend_q & ~ack_hit;
      pend_d  = rise | (pend_q & ~ack_hit);
      ovf_d   = (ovf_q & ~{WIDTH{ovf_clr}}) | ovf_set;
    end else begin
      pend_d  = sync_s;
      ovf_d   = '0;
    end
    mask_d = mask_we ? mask_wdata : mask_q;
  end

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      pend_q <= '0;
      ovf_q  <= '0;
      mask_q <= MASK_RESET;
    end else begin
      hist_q <= sync_s;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      mask_q <= mask_d;
    end
  end

  assign pending    = pend_q;
  assign overflow   = ovf_q;
  assign mask       = mask_q;
  assign interrupts = pend_q & mask_q;
  assign irq_any    = |interrupts;

  always_comb begin
    irq_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (interrupts[i]) irq_idx = 3'(i);
    end
  end

endmodule
